// File: rtl/conv_adder_tree_acc.sv
// Pipelined signed adder tree with per-frame channel accumulation.
// Reduces NUM_INPUTS operands per beat and accumulates beat sums until a last
// beat arrives, or until MAX_CHANNELS beats have been seen.
module conv_adder_tree_acc #(
  parameter int unsigned DATA_WIDTH   = 19,
  parameter int unsigned NUM_INPUTS   = 9,
  parameter int unsigned MAX_CHANNELS = 4,
  localparam int unsigned TREE_LEVELS = $clog2(NUM_INPUTS),
  localparam int unsigned OUT_WIDTH   = DATA_WIDTH + TREE_LEVELS + $clog2(MAX_CHANNELS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             in_valid,
  input  logic                             in_last,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0] in_data,
  output logic                             out_valid,
  output logic [OUT_WIDTH-1:0]             out_data,
  output logic                             chan_overflow
);

  localparam int unsigned CNT_W = $clog2(MAX_CHANNELS + 1);
  localparam int unsigned SRC_W = 2 * NUM_INPUTS;

  // src[j] feeds register level j+1; entries past the live node count stay 0, so
  // an odd leftover node is summed with 0 and passes through unchanged.
  logic signed [OUT_WIDTH-1:0] src    [TREE_LEVELS][SRC_W];
  logic signed [OUT_WIDTH-1:0] tree_q [TREE_LEVELS][NUM_INPUTS];
  logic [TREE_LEVELS-1:0]      vld_q;
  logic [TREE_LEVELS-1:0]      lst_q;

  logic signed [OUT_WIDTH-1:0] tree_sum;
  logic signed [OUT_WIDTH-1:0] acc_q;
  logic signed [OUT_WIDTH-1:0] acc_sum;
  logic signed [OUT_WIDTH-1:0] out_data_q;
  logic [CNT_W-1:0]            chan_cnt_q;
  logic [CNT_W-1:0]            cnt_next;
  logic                        first_beat_q;
  logic                        out_valid_q;
  logic                        ovf_q;
  logic                        cnt_full;
  logic                        done;
  logic                        set_ovf;

  // Level 0 sign-extension and wiring of each register level to the next.
  always_comb begin
    for (int j = 0; j < TREE_LEVELS; j++) begin
      for (int i = 0; i < SRC_W; i++) begin
        src[j][i] = '0;
      end
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      src[0][i] = OUT_WIDTH'($signed(in_data[i*DATA_WIDTH +: DATA_WIDTH]));
    end
    for (int j = 1; j < TREE_LEVELS; j++) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        src[j][i] = tree_q[j-1][i];
      end
    end
  end

  // Tree registers plus the valid/last shift pipeline that tracks them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < TREE_LEVELS; j++) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          tree_q[j][i] <= '0;
        end
      end
      vld_q <= '0;
      lst_q <= '0;
    end else if (enable) begin
      for (int j = 0; j < TREE_LEVELS; j++) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          tree_q[j][i] <= src[j][2*i] + src[j][2*i+1];
        end
      end
      vld_q[0] <= in_valid;
      lst_q[0] <= in_last;
      for (int j = 1; j < TREE_LEVELS; j++) begin
        vld_q[j] <= vld_q[j-1];
        lst_q[j] <= lst_q[j-1];
      end
    end
  end

  assign tree_sum = tree_q[TREE_LEVELS-1][0];

  // Accumulator next-state: restart from 0 on the first beat of a frame.
  always_comb begin
    acc_sum  = (first_beat_q ? '0 : acc_q) + tree_sum;
    cnt_next = first_beat_q ? CNT_W'(1) : chan_cnt_q + CNT_W'(1);
    cnt_full = (cnt_next == CNT_W'(MAX_CHANNELS));
    done     = lst_q[TREE_LEVELS-1] || cnt_full;
    // A single-channel configuration completes every beat by design, not by overflow.
    set_ovf  = (MAX_CHANNELS > 1) && !lst_q[TREE_LEVELS-1] && cnt_full;
  end

  // Accumulator stage; invalid tree beats only drop out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q        <= '0;
      chan_cnt_q   <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      ovf_q        <= 1'b0;
      first_beat_q <= 1'b1;
    end else if (enable) begin
      if (vld_q[TREE_LEVELS-1]) begin
        acc_q      <= acc_sum;
        chan_cnt_q <= cnt_next;
        if (done) begin
          out_data_q   <= acc_sum;
          out_valid_q  <= 1'b1;
          first_beat_q <= 1'b1;
        end else begin
          out_valid_q  <= 1'b0;
          first_beat_q <= 1'b0;
        end
        if (set_ovf) begin
          ovf_q <= 1'b1;
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign chan_overflow = ovf_q;

endmodule

// File: tb/tb_conv_adder_tree_acc.sv
// Directed bench for conv_adder_tree_acc with the default 19-bit x 9 x 4 configuration.
module tb_conv_adder_tree_acc;

  localparam int DW = 19;
  localparam int NI = 9;
  localparam int OW = 25;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic           in_valid;
  logic           in_last;
  logic [DW*NI-1:0] in_data;
  logic           out_valid;
  logic [OW-1:0]  out_data;
  logic           chan_overflow;

  int passed = 0;
  int total  = 0;
  int n;
  int pulses;

  always #5 clk = ~clk;

  conv_adder_tree_acc #(
    .DATA_WIDTH  (DW),
    .NUM_INPUTS  (NI),
    .MAX_CHANNELS(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .chan_overflow(chan_overflow)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW*NI-1:0] fill(input int v);
    logic [DW*NI-1:0] r;
    for (int k = 0; k < NI; k++) r[k*DW +: DW] = v[DW-1:0];
    return r;
  endfunction

  function automatic logic [DW*NI-1:0] alt_extremes();
    logic [DW*NI-1:0] r;
    int t;
    for (int k = 0; k < NI; k++) begin
      t = (k % 2 == 0) ? 262143 : -262144;
      r[k*DW +: DW] = t[DW-1:0];
    end
    return r;
  endfunction

  // Presents one beat and takes the edge that samples it.
  task automatic beat(input logic [DW*NI-1:0] d, input logic last);
    in_valid = 1'b1;
    in_last  = last;
    in_data  = d;
    tick();
  endtask

  // Idles the inputs and ticks until out_valid; cnt is edges since the beat was sampled.
  task automatic wait_valid(input int start, output int cnt);
    in_valid = 1'b0;
    in_last  = 1'b0;
    cnt = start;
    while (!out_valid && cnt < start + 20) begin
      tick();
      cnt++;
    end
  endtask

  task automatic count_pulses(input int cycles, output int c);
    c = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (out_valid) c++;
    end
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_data", $signed(out_data), 0);
    check("reset_overflow", 32'(chan_overflow), 0);

    // Single one-beat frame of ones.
    beat(fill(1), 1'b1);
    wait_valid(1, n);
    check("ones_latency", n, 5);
    check("ones_data", $signed(out_data), 9);
    check("ones_overflow", 32'(chan_overflow), 0);
    tick();
    check("ones_strobe_drops", 32'(out_valid), 0);

    // Operand extremes.
    beat(alt_extremes(), 1'b1);
    wait_valid(1, n);
    check("alt_latency", n, 5);
    check("alt_data", $signed(out_data), 262139);
    beat(fill(-262144), 1'b1);
    wait_valid(1, n);
    check("neg_latency", n, 5);
    check("neg_data", $signed(out_data), -2359296);

    // Three-channel accumulation, then a fresh frame.
    beat(fill(2), 1'b0);
    beat(fill(2), 1'b0);
    beat(fill(2), 1'b1);
    wait_valid(1, n);
    check("acc3_latency", n, 5);
    check("acc3_data", $signed(out_data), 54);
    beat(fill(1), 1'b1);
    wait_valid(1, n);
    check("restart_data", $signed(out_data), 9);

    // Back-to-back frames: 9 then 18 on consecutive cycles.
    beat(fill(1), 1'b1);
    beat(fill(2), 1'b1);
    wait_valid(2, n);
    check("b2b_first_latency", n, 5);
    check("b2b_first_data", $signed(out_data), 9);
    tick();
    check("b2b_second_valid", 32'(out_valid), 1);
    check("b2b_second_data", $signed(out_data), 18);

    // Frame without last: forced completion after four beats.
    check("pre_overflow", 32'(chan_overflow), 0);
    for (int b = 0; b < 4; b++) beat(fill(1), 1'b0);
    wait_valid(1, n);
    check("force_latency", n, 5);
    check("force_data", $signed(out_data), 36);
    check("force_overflow", 32'(chan_overflow), 1);
    tick();
    tick();
    check("force_strobe_drops", 32'(out_valid), 0);
    check("overflow_sticky", 32'(chan_overflow), 1);

    // Enable dropped for three cycles mid-pipeline.
    beat(fill(1), 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    enable = 1'b0;
    tick();
    tick();
    tick();
    enable = 1'b1;
    wait_valid(5, n);
    check("stall_latency", n, 8);
    check("stall_data", $signed(out_data), 9);
    enable = 1'b0;
    tick();
    check("stall_valid_held", 32'(out_valid), 1);
    check("stall_data_held", $signed(out_data), 9);
    enable = 1'b1;
    tick();
    check("stall_valid_released", 32'(out_valid), 0);
    check("overflow_still_sticky", 32'(chan_overflow), 1);

    // A beat presented while disabled is not sampled.
    enable   = 1'b0;
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = fill(1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    enable   = 1'b1;
    count_pulses(8, pulses);
    check("disabled_beat_ignored", pulses, 0);

    // Reset two cycles after a last beat enters, taken with enable low.
    beat(fill(1), 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    reset  = 1'b0;
    enable = 1'b1;
    check("midreset_out_valid", 32'(out_valid), 0);
    check("midreset_out_data", $signed(out_data), 0);
    check("midreset_overflow", 32'(chan_overflow), 0);
    count_pulses(8, pulses);
    check("midreset_flushed", pulses, 0);
    beat(fill(1), 1'b0);
    beat(fill(1), 1'b1);
    wait_valid(1, n);
    check("post_reset_latency", n, 5);
    check("post_reset_data", $signed(out_data), 18);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
